// File: rtl/ct_had_dbgreq_ctrl.sv
// HAD debug-request controller: arbitrates trace/breakpoint/JTAG halt requests,
// drives the registered RTU debug request and tracks halt status for HSR.
module ct_had_dbgreq_ctrl #(
  parameter int TMO_W     = 8,
  parameter int TMO_LIMIT = 200
) (
  input  logic        cpuclk,
  input  logic        cpurst_b,
  input  logic        trace_ctrl_req,
  input  logic        inst_bkpt_dbgreq,
  input  logic        jtag_halt_req,
  input  logic        rtu_yy_xx_dbgon,
  input  logic        ctrl_exit_dbg,
  input  logic        x_sm_xx_update_dr_en,
  input  logic        ir_xx_hsr_reg_sel,
  input  logic [63:0] ir_xx_wdata,
  output logic        had_rtu_dbg_req,
  output logic        dbgreq_ctrl_busy,
  output logic [2:0]  dbgreq_regs_reason,
  output logic        dbgreq_regs_ack_err,
  output logic [7:0]  dbgreq_regs_trace_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_REQ   = 2'b01,
    ST_DEBUG = 2'b10,
    ST_EXIT  = 2'b11
  } state_t;

  localparam logic [TMO_W-1:0] TMO_MAX    = TMO_W'(TMO_LIMIT);
  localparam logic [TMO_W-1:0] TMO_PRE    = TMO_W'(TMO_LIMIT - 1);
  localparam logic [2:0]       RSN_NONE   = 3'b000;
  localparam logic [2:0]       RSN_TRACE  = 3'b001;

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic [2:0]        reason_q, reason_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              ack_err_q, ack_err_d;
  logic [7:0]        trace_cnt_q, trace_cnt_d;

  logic              any_req_s;
  logic [2:0]        req_reason_s;
  logic              hsr_wr_s;
  logic              ack_set_s;
  logic              trace_inc_s;
  logic              wdata_unused_s;

  function automatic logic [2:0] reason_enc(input logic jtag, input logic bkpt,
                                            input logic trace);
    logic [2:0] code;
    if (jtag)       code = 3'b100;
    else if (bkpt)  code = 3'b010;
    else if (trace) code = 3'b001;
    else            code = 3'b000;
    return code;
  endfunction

  assign any_req_s      = trace_ctrl_req | inst_bkpt_dbgreq | jtag_halt_req;
  assign req_reason_s   = reason_enc(jtag_halt_req, inst_bkpt_dbgreq, trace_ctrl_req);
  assign hsr_wr_s       = x_sm_xx_update_dr_en & ir_xx_hsr_reg_sel;
  assign wdata_unused_s = ^ir_xx_wdata[63:2];

  // Next-state and status update logic
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    reason_d    = reason_q;
    tmo_d       = tmo_q;
    ack_set_s   = 1'b0;
    trace_inc_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_d = 1'b0;
        // An acknowledge already present means the core entered debug on its own
        if (rtu_yy_xx_dbgon) begin
          state_d  = ST_DEBUG;
          reason_d = RSN_NONE;
        end else if (any_req_s) begin
          state_d     = ST_REQ;
          reason_d    = req_reason_s;
          tmo_d       = {TMO_W{1'b0}};
          req_d       = 1'b1;
          trace_inc_s = (req_reason_s == RSN_TRACE);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (rtu_yy_xx_dbgon) begin
          state_d = ST_DEBUG;
          req_d   = 1'b0;
        end else begin
          req_d = 1'b1;
          if (tmo_q != TMO_MAX) begin
            tmo_d     = tmo_q + TMO_W'(1);
            ack_set_s = (tmo_q == TMO_PRE);
          end else begin
            tmo_d = tmo_q;
          end
        end
      end
      ST_DEBUG: begin
        req_d = 1'b0;
        if (ctrl_exit_dbg)         state_d = ST_EXIT;
        else if (!rtu_yy_xx_dbgon) state_d = ST_IDLE;
        else                       state_d = ST_DEBUG;
      end
      ST_EXIT: begin
        req_d = 1'b0;
        if (!rtu_yy_xx_dbgon) state_d = ST_IDLE;
        else                  state_d = ST_EXIT;
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase

    // Set beats clear; a clear coinciding with an increment leaves one count
    if (ack_set_s)                      ack_err_d = 1'b1;
    else if (hsr_wr_s && ir_xx_wdata[0]) ack_err_d = 1'b0;
    else                                ack_err_d = ack_err_q;

    if (trace_inc_s && hsr_wr_s && ir_xx_wdata[1])   trace_cnt_d = 8'd1;
    else if (hsr_wr_s && ir_xx_wdata[1])             trace_cnt_d = 8'd0;
    else if (trace_inc_s && trace_cnt_q != 8'hFF)    trace_cnt_d = trace_cnt_q + 8'd1;
    else                                             trace_cnt_d = trace_cnt_q;
  end

  // State and status registers with asynchronous clear
  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q     <= ST_IDLE;
      req_q       <= 1'b0;
      reason_q    <= 3'b000;
      tmo_q       <= {TMO_W{1'b0}};
      ack_err_q   <= 1'b0;
      trace_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      reason_q    <= reason_d;
      tmo_q       <= tmo_d;
      ack_err_q   <= ack_err_d;
      trace_cnt_q <= trace_cnt_d;
    end
  end

  assign had_rtu_dbg_req       = req_q;
  assign dbgreq_ctrl_busy      = (state_q != ST_IDLE);
  assign dbgreq_regs_reason    = reason_q;
  assign dbgreq_regs_ack_err   = ack_err_q;
  assign dbgreq_regs_trace_cnt = trace_cnt_q;

endmodule

// File: tb/tb_ct_had_dbgreq_ctrl.sv
// Directed self-checking bench for ct_had_dbgreq_ctrl; inputs are driven and
// outputs sampled on the falling clock edge.
module tb_ct_had_dbgreq_ctrl;

  logic        cpuclk;
  logic        cpurst_b;
  logic        trace_ctrl_req;
  logic        inst_bkpt_dbgreq;
  logic        jtag_halt_req;
  logic        rtu_yy_xx_dbgon;
  logic        ctrl_exit_dbg;
  logic        x_sm_xx_update_dr_en;
  logic        ir_xx_hsr_reg_sel;
  logic [63:0] ir_xx_wdata;
  logic        had_rtu_dbg_req;
  logic        dbgreq_ctrl_busy;
  logic [2:0]  dbgreq_regs_reason;
  logic        dbgreq_regs_ack_err;
  logic [7:0]  dbgreq_regs_trace_cnt;

  int n_checks;
  int n_fail;

  ct_had_dbgreq_ctrl #(.TMO_W(8), .TMO_LIMIT(200)) dut (
    .cpuclk               (cpuclk),
    .cpurst_b             (cpurst_b),
    .trace_ctrl_req       (trace_ctrl_req),
    .inst_bkpt_dbgreq     (inst_bkpt_dbgreq),
    .jtag_halt_req        (jtag_halt_req),
    .rtu_yy_xx_dbgon      (rtu_yy_xx_dbgon),
    .ctrl_exit_dbg        (ctrl_exit_dbg),
    .x_sm_xx_update_dr_en (x_sm_xx_update_dr_en),
    .ir_xx_hsr_reg_sel    (ir_xx_hsr_reg_sel),
    .ir_xx_wdata          (ir_xx_wdata),
    .had_rtu_dbg_req      (had_rtu_dbg_req),
    .dbgreq_ctrl_busy     (dbgreq_ctrl_busy),
    .dbgreq_regs_reason   (dbgreq_regs_reason),
    .dbgreq_regs_ack_err  (dbgreq_regs_ack_err),
    .dbgreq_regs_trace_cnt(dbgreq_regs_trace_cnt)
  );

  initial cpuclk = 1'b0;
  always #5 cpuclk = ~cpuclk;

  task automatic do_reset();
    cpurst_b = 1'b0;
    trace_ctrl_req = 1'b0; inst_bkpt_dbgreq = 1'b0; jtag_halt_req = 1'b0;
    rtu_yy_xx_dbgon = 1'b0; ctrl_exit_dbg = 1'b0;
    x_sm_xx_update_dr_en = 1'b0; ir_xx_hsr_reg_sel = 1'b0; ir_xx_wdata = 64'd0;
    repeat (2) @(negedge cpuclk);
    cpurst_b = 1'b1;
    @(negedge cpuclk);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({had_rtu_dbg_req, dbgreq_ctrl_busy, dbgreq_regs_reason, dbgreq_regs_ack_err,
         dbgreq_regs_trace_cnt} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_state: got req=%b busy=%b rsn=%b ack=%b cnt=%0d, want all 0",
               had_rtu_dbg_req, dbgreq_ctrl_busy, dbgreq_regs_reason,
               dbgreq_regs_ack_err, dbgreq_regs_trace_cnt);
    end
  endtask

  task automatic test_trace_halt();
    do_reset();
    repeat (4) @(negedge cpuclk);
    trace_ctrl_req = 1'b1;
    @(negedge cpuclk);
    trace_ctrl_req = 1'b0;
    n_checks++;
    if ({had_rtu_dbg_req, dbgreq_ctrl_busy, dbgreq_regs_reason, dbgreq_regs_trace_cnt}
        !== {1'b1, 1'b1, 3'b001, 8'd1}) begin
      n_fail++;
      $display("FAIL trace_req: got req=%b busy=%b rsn=%b cnt=%0d, want 1 1 001 1",
               had_rtu_dbg_req, dbgreq_ctrl_busy, dbgreq_regs_reason, dbgreq_regs_trace_cnt);
    end
    repeat (3) @(negedge cpuclk);
    n_checks++;
    if (had_rtu_dbg_req !== 1'b1) begin
      n_fail++;
      $display("FAIL req_held: got %b want 1", had_rtu_dbg_req);
    end
    rtu_yy_xx_dbgon = 1'b1;
    @(negedge cpuclk);
    n_checks++;
    if ({had_rtu_dbg_req, dbgreq_ctrl_busy, dbgreq_regs_trace_cnt} !== {1'b0, 1'b1, 8'd1}) begin
      n_fail++;
      $display("FAIL ack_debug: got req=%b busy=%b cnt=%0d, want 0 1 1",
               had_rtu_dbg_req, dbgreq_ctrl_busy, dbgreq_regs_trace_cnt);
    end
  endtask

  // Continues from DEBUG with dbgon high, as left by test_trace_halt
  task automatic test_exit();
    ctrl_exit_dbg = 1'b1;
    @(negedge cpuclk);
    ctrl_exit_dbg = 1'b0;
    trace_ctrl_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge cpuclk);
      n_checks++;
      if ({had_rtu_dbg_req, dbgreq_ctrl_busy, dbgreq_regs_trace_cnt} !== {1'b0, 1'b1, 8'd1}) begin
        n_fail++;
        $display("FAIL exit_hold[%0d]: got req=%b busy=%b cnt=%0d, want 0 1 1", i,
                 had_rtu_dbg_req, dbgreq_ctrl_busy, dbgreq_regs_trace_cnt);
      end
    end
    rtu_yy_xx_dbgon = 1'b0;
    @(negedge cpuclk);
    n_checks++;
    if ({had_rtu_dbg_req, dbgreq_ctrl_busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL exit_idle: got req=%b busy=%b, want 0 0", had_rtu_dbg_req, dbgreq_ctrl_busy);
    end
    @(negedge cpuclk);
    trace_ctrl_req = 1'b0;
    n_checks++;
    if ({had_rtu_dbg_req, dbgreq_regs_trace_cnt} !== {1'b1, 8'd2}) begin
      n_fail++;
      $display("FAIL reentry: got req=%b cnt=%0d, want 1 2", had_rtu_dbg_req, dbgreq_regs_trace_cnt);
    end
    rtu_yy_xx_dbgon = 1'b1;
    @(negedge cpuclk);
    rtu_yy_xx_dbgon = 1'b0;
    @(negedge cpuclk);
    n_checks++;
    if (dbgreq_ctrl_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL dbgon_drop: got busy=%b want 0", dbgreq_ctrl_busy);
    end
  endtask

  task automatic test_priority();
    do_reset();
    trace_ctrl_req = 1'b1; inst_bkpt_dbgreq = 1'b1; jtag_halt_req = 1'b1;
    @(negedge cpuclk);
    trace_ctrl_req = 1'b0; inst_bkpt_dbgreq = 1'b0; jtag_halt_req = 1'b0;
    n_checks++;
    if ({had_rtu_dbg_req, dbgreq_regs_reason, dbgreq_regs_trace_cnt} !== {1'b1, 3'b100, 8'd0}) begin
      n_fail++;
      $display("FAIL prio_jtag: got req=%b rsn=%b cnt=%0d, want 1 100 0",
               had_rtu_dbg_req, dbgreq_regs_reason, dbgreq_regs_trace_cnt);
    end
    rtu_yy_xx_dbgon = 1'b1;
    @(negedge cpuclk);
    rtu_yy_xx_dbgon = 1'b0;
    @(negedge cpuclk);
    trace_ctrl_req = 1'b1; inst_bkpt_dbgreq = 1'b1;
    @(negedge cpuclk);
    trace_ctrl_req = 1'b0; inst_bkpt_dbgreq = 1'b0;
    n_checks++;
    if ({had_rtu_dbg_req, dbgreq_regs_reason, dbgreq_regs_trace_cnt} !== {1'b1, 3'b010, 8'd0}) begin
      n_fail++;
      $display("FAIL prio_bkpt: got req=%b rsn=%b cnt=%0d, want 1 010 0",
               had_rtu_dbg_req, dbgreq_regs_reason, dbgreq_regs_trace_cnt);
    end
    rtu_yy_xx_dbgon = 1'b1;
    @(negedge cpuclk);
    rtu_yy_xx_dbgon = 1'b0;
    @(negedge cpuclk);
  endtask

  // Continues from IDLE with reason 010 left by test_priority
  task automatic test_unsolicited();
    rtu_yy_xx_dbgon = 1'b1;
    @(negedge cpuclk);
    trace_ctrl_req = 1'b1;
    n_checks++;
    if ({had_rtu_dbg_req, dbgreq_ctrl_busy, dbgreq_regs_reason} !== {1'b0, 1'b1, 3'b000}) begin
      n_fail++;
      $display("FAIL unsolicited: got req=%b busy=%b rsn=%b, want 0 1 000",
               had_rtu_dbg_req, dbgreq_ctrl_busy, dbgreq_regs_reason);
    end
    @(negedge cpuclk);
    n_checks++;
    if ({had_rtu_dbg_req, dbgreq_regs_trace_cnt} !== {1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL debug_ignores_req: got req=%b cnt=%0d, want 0 0",
               had_rtu_dbg_req, dbgreq_regs_trace_cnt);
    end
    trace_ctrl_req = 1'b0;
    rtu_yy_xx_dbgon = 1'b0;
    @(negedge cpuclk);
    n_checks++;
    if ({had_rtu_dbg_req, dbgreq_ctrl_busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL unsolicited_idle: got req=%b busy=%b, want 0 0",
               had_rtu_dbg_req, dbgreq_ctrl_busy);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    trace_ctrl_req = 1'b1;
    @(negedge cpuclk);
    trace_ctrl_req = 1'b0;
    for (int k = 1; k < 200; k++) begin
      @(negedge cpuclk);
      n_checks++;
      if ({dbgreq_regs_ack_err, had_rtu_dbg_req} !== 2'b01) begin
        n_fail++;
        $display("FAIL tmo_early[%0d]: got ack=%b req=%b, want 0 1", k,
                 dbgreq_regs_ack_err, had_rtu_dbg_req);
      end
    end
    // Clear lands on the same edge that sets the flag
    x_sm_xx_update_dr_en = 1'b1; ir_xx_hsr_reg_sel = 1'b1; ir_xx_wdata = 64'd1;
    @(negedge cpuclk);
    n_checks++;
    if ({dbgreq_regs_ack_err, had_rtu_dbg_req} !== 2'b11) begin
      n_fail++;
      $display("FAIL tmo_set_wins: got ack=%b req=%b, want 1 1", dbgreq_regs_ack_err, had_rtu_dbg_req);
    end
    ir_xx_hsr_reg_sel = 1'b0; ir_xx_wdata = 64'd3;
    @(negedge cpuclk);
    n_checks++;
    if ({dbgreq_regs_ack_err, dbgreq_regs_trace_cnt} !== {1'b1, 8'd1}) begin
      n_fail++;
      $display("FAIL hsr_unselected: got ack=%b cnt=%0d, want 1 1",
               dbgreq_regs_ack_err, dbgreq_regs_trace_cnt);
    end
    ir_xx_hsr_reg_sel = 1'b1; ir_xx_wdata = 64'd1;
    @(negedge cpuclk);
    x_sm_xx_update_dr_en = 1'b0; ir_xx_hsr_reg_sel = 1'b0; ir_xx_wdata = 64'd0;
    n_checks++;
    if ({dbgreq_regs_ack_err, had_rtu_dbg_req, dbgreq_regs_trace_cnt} !== {1'b0, 1'b1, 8'd1}) begin
      n_fail++;
      $display("FAIL ack_clear: got ack=%b req=%b cnt=%0d, want 0 1 1",
               dbgreq_regs_ack_err, had_rtu_dbg_req, dbgreq_regs_trace_cnt);
    end
    rtu_yy_xx_dbgon = 1'b1;
    @(negedge cpuclk);
    rtu_yy_xx_dbgon = 1'b0;
    @(negedge cpuclk);
  endtask

  task automatic test_trace_sat();
    do_reset();
    for (int h = 1; h <= 260; h++) begin
      trace_ctrl_req = 1'b1;
      @(negedge cpuclk);
      trace_ctrl_req = 1'b0;
      rtu_yy_xx_dbgon = 1'b1;
      @(negedge cpuclk);
      rtu_yy_xx_dbgon = 1'b0;
      @(negedge cpuclk);
      if (h == 254) begin
        n_checks++;
        if (dbgreq_regs_trace_cnt !== 8'hFE) begin
          n_fail++;
          $display("FAIL cnt_254: got %0d want 254", dbgreq_regs_trace_cnt);
        end
      end
    end
    n_checks++;
    if (dbgreq_regs_trace_cnt !== 8'hFF) begin
      n_fail++;
      $display("FAIL cnt_sat: got %0d want 255", dbgreq_regs_trace_cnt);
    end
    trace_ctrl_req = 1'b1;
    x_sm_xx_update_dr_en = 1'b1; ir_xx_hsr_reg_sel = 1'b1; ir_xx_wdata = 64'd2;
    @(negedge cpuclk);
    trace_ctrl_req = 1'b0;
    x_sm_xx_update_dr_en = 1'b0; ir_xx_hsr_reg_sel = 1'b0; ir_xx_wdata = 64'd0;
    n_checks++;
    if ({dbgreq_regs_trace_cnt, had_rtu_dbg_req} !== {8'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL cnt_clr_inc: got cnt=%0d req=%b, want 1 1", dbgreq_regs_trace_cnt, had_rtu_dbg_req);
    end
    rtu_yy_xx_dbgon = 1'b1;
    @(negedge cpuclk);
    rtu_yy_xx_dbgon = 1'b0;
    @(negedge cpuclk);
  endtask

  task automatic test_async_reset();
    do_reset();
    trace_ctrl_req = 1'b1;
    @(negedge cpuclk);
    trace_ctrl_req = 1'b0;
    n_checks++;
    if ({had_rtu_dbg_req, dbgreq_regs_reason, dbgreq_regs_trace_cnt} !== {1'b1, 3'b001, 8'd1}) begin
      n_fail++;
      $display("FAIL pre_reset: got req=%b rsn=%b cnt=%0d, want 1 001 1",
               had_rtu_dbg_req, dbgreq_regs_reason, dbgreq_regs_trace_cnt);
    end
    #2 cpurst_b = 1'b0;
    #1;
    n_checks++;
    if ({had_rtu_dbg_req, dbgreq_ctrl_busy, dbgreq_regs_reason, dbgreq_regs_ack_err,
         dbgreq_regs_trace_cnt} !== 14'd0) begin
      n_fail++;
      $display("FAIL async_reset: got req=%b busy=%b rsn=%b ack=%b cnt=%0d, want all 0",
               had_rtu_dbg_req, dbgreq_ctrl_busy, dbgreq_regs_reason,
               dbgreq_regs_ack_err, dbgreq_regs_trace_cnt);
    end
    @(negedge cpuclk);
    cpurst_b = 1'b1;
    @(negedge cpuclk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_trace_halt();
    test_exit();
    test_priority();
    test_unsolicited();
    test_timeout();
    test_trace_sat();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
